multicycle_ctrl: RTL and testbench

Multi-cycle control unit that sequences the processor datapath: it steps each instruction through fetch, decode, execute, memory and write-back states. It drives the select lines of the datapath multiplexers (ALU operand B, register destination, write-back source, next PC) and the enables for the PC, IR, register file and data memory. A bounded data-memory handshake with timeout lets the datapath run against a slow memory port.

---
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing,
// datapath select/enable generation and bounded data-memory wait.
module multicycle_ctrl #(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        dm_ready,
   output logic        pc_we,
   output logic        ir_we,
   output logic        reg_we,
   output logic        dm_re,
   output logic        dm_we,
   output logic        alu_src_sel,
   output logic [1:0]  reg_dst_sel,
   output logic [1:0]  wb_sel,
   output logic [1:0]  npc_sel,
   output logic [2:0]  alu_op,
   output logic        illegal,
   output logic        mem_err,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      C_NONE, C_R, C_ORI, C_LUI, C_LW,
      C_SW, C_BEQ, C_J, C_JAL, C_ILL
   } cls_t;

   state_t      r_state, w_next;
   cls_t        r_cls, w_cls;
   logic [2:0]  r_alu, w_alu;
   logic [7:0]  r_wait;
   logic [31:0] r_ret;
   logic        w_retire;

   logic        w_pc_we, w_ir_we, w_reg_we;
   logic        w_dm_re, w_dm_we, w_alu_src;
   logic [1:0]  w_reg_dst, w_wb, w_npc;
   logic [2:0]  w_alu_op;
   logic        w_ill, w_merr;

   always_comb begin
      w_cls = C_ILL;
      w_alu = 3'd0;
      case (op)
         6'b000000: begin
            case (funct)
               6'b100001: begin w_cls = C_R; w_alu = 3'd0; end
               6'b100011: begin w_cls = C_R; w_alu = 3'd1; end
               6'b101010: begin w_cls = C_R; w_alu = 3'd3; end
               default:   w_cls = C_ILL;
            endcase
         end
         6'b001101: begin w_cls = C_ORI; w_alu = 3'd2; end
         6'b001111: begin w_cls = C_LUI; w_alu = 3'd4; end
         6'b100011: w_cls = C_LW;
         6'b101011: w_cls = C_SW;
         6'b000100: begin w_cls = C_BEQ; w_alu = 3'd1; end
         6'b000010: w_cls = C_J;
         6'b000011: w_cls = C_JAL;
         default:   w_cls = C_ILL;
      endcase
   end

   always_comb begin
      w_next    = r_state;
      w_retire  = 1'b0;
      w_pc_we   = 1'b0;
      w_ir_we   = 1'b0;
      w_reg_we  = 1'b0;
      w_dm_re   = 1'b0;
      w_dm_we   = 1'b0;
      w_alu_src = 1'b0;
      w_reg_dst = 2'b00;
      w_wb      = 2'b00;
      w_npc     = 2'b00;
      w_alu_op  = 3'd0;
      w_ill     = 1'b0;
      w_merr    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_ir_we = 1'b1;
            w_pc_we = 1'b1;
            w_next  = S_DECODE;
         end
         S_DECODE: begin
            w_next = S_EXEC;
            case (w_cls)
               C_J: begin
                  w_pc_we  = 1'b1;
                  w_npc    = 2'b10;
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end
               C_JAL: begin
                  w_pc_we   = 1'b1;
                  w_npc     = 2'b10;
                  w_reg_we  = 1'b1;
                  w_reg_dst = 2'b10;
                  w_wb      = 2'b10;
                  w_next    = S_FETCH;
                  w_retire  = 1'b1;
               end
               C_ILL: begin
                  w_ill  = 1'b1;
                  w_next = S_FETCH;
               end
               default: w_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            w_alu_op  = r_alu;
            w_alu_src = (r_cls == C_ORI) || (r_cls == C_LUI) ||
                        (r_cls == C_LW)  || (r_cls == C_SW);
            case (r_cls)
               C_BEQ: begin
                  w_pc_we  = zero;
                  w_npc    = zero ? 2'b01 : 2'b00;
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end
               C_LW, C_SW: w_next = S_MEM;
               default:    w_next = S_WB;
            endcase
         end
         S_MEM: begin
            w_dm_re = (r_cls == C_LW);
            w_dm_we = (r_cls == C_SW);
            if (dm_ready) begin
               if (r_cls == C_LW) begin
                  w_next = S_WB;
               end else begin
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end
            end else if (r_wait == 8'(WAIT_MAX)) begin
               w_merr = 1'b1;
               w_next = S_FETCH;
            end
         end
         S_WB: begin
            w_reg_we  = 1'b1;
            w_reg_dst = (r_cls == C_R) ? 2'b01 : 2'b00;
            w_wb      = (r_cls == C_LW) ? 2'b01 : 2'b00;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_cls   <= C_NONE;
         r_alu   <= 3'd0;
         r_wait  <= 8'd0;
         r_ret   <= 32'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_cls <= w_cls;
            r_alu <= w_alu;
         end
         // counter is zero whenever outside S_MEM, so entry always starts at 0
         if (r_state != S_MEM || w_next != S_MEM)
            r_wait <= 8'd0;
         else
            r_wait <= r_wait + 8'd1;
         if (w_retire)
            r_ret <= r_ret + 32'd1;
      end
   end

   assign pc_we       = w_pc_we   & ~rst;
   assign ir_we       = w_ir_we   & ~rst;
   assign reg_we      = w_reg_we  & ~rst;
   assign dm_re       = w_dm_re   & ~rst;
   assign dm_we       = w_dm_we   & ~rst;
   assign alu_src_sel = w_alu_src & ~rst;
   assign illegal     = w_ill     & ~rst;
   assign mem_err     = w_merr    & ~rst;
   assign reg_dst_sel = rst ? 2'b00 : w_reg_dst;
   assign wb_sel      = rst ? 2'b00 : w_wb;
   assign npc_sel     = rst ? 2'b00 : w_npc;
   assign alu_op      = rst ? 3'd0  : w_alu_op;
   assign retired     = r_ret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expected output
// traces are queued by the driver and checked every cycle by a monitor.
module tb_multicycle_ctrl;

   localparam int WM = 15;
   localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_BADF = 3;
   localparam int K_ORI = 4, K_LUI = 5, K_LW = 6, K_SW = 7;
   localparam int K_BEQ = 8, K_J = 9, K_JAL = 10, K_ILL = 11;

   typedef struct packed {
      logic        pc_we;
      logic        ir_we;
      logic        reg_we;
      logic        dm_re;
      logic        dm_we;
      logic        alu_src;
      logic [1:0]  reg_dst;
      logic [1:0]  wb;
      logic [1:0]  npc;
      logic [2:0]  alu_op;
      logic        ill;
      logic        merr;
      logic [31:0] ret;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op, funct;
   logic        zero, dm_ready;
   logic        pc_we, ir_we, reg_we, dm_re, dm_we, alu_src_sel;
   logic [1:0]  reg_dst_sel, wb_sel, npc_sel;
   logic [2:0]  alu_op;
   logic        illegal, mem_err;
   logic [31:0] retired;
   obs_t        act;

   obs_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          mon_en = 1'b0;
   int unsigned m_ret = 0;

   multicycle_ctrl #(.WAIT_MAX(WM)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct),
      .zero(zero), .dm_ready(dm_ready),
      .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
      .dm_re(dm_re), .dm_we(dm_we), .alu_src_sel(alu_src_sel),
      .reg_dst_sel(reg_dst_sel), .wb_sel(wb_sel), .npc_sel(npc_sel),
      .alu_op(alu_op), .illegal(illegal), .mem_err(mem_err),
      .retired(retired)
   );

   assign act = {pc_we, ir_we, reg_we, dm_re, dm_we, alu_src_sel,
                 reg_dst_sel, wb_sel, npc_sel, alu_op, illegal,
                 mem_err, retired};

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && exp_q.size() > 0)
         chk("trace", act, exp_q.pop_front());
   end

   function automatic bit legal_op(logic [5:0] o);
      return o inside {6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b,
                       6'h04, 6'h02, 6'h03};
   endfunction

   // d = S_MEM cycle index on which dm_ready rises; d > WM means never
   task automatic run_instr(int k, bit z, int d, logic [5:0] ill_op);
      obs_t tr[$];
      bit   rdy[$];
      obs_t v;
      bit   ok, ret;
      int   n;
      funct = 6'($urandom);
      case (k)
         K_ADDU: begin op = 6'h00; funct = 6'h21; end
         K_SUBU: begin op = 6'h00; funct = 6'h23; end
         K_SLT:  begin op = 6'h00; funct = 6'h2a; end
         K_BADF: begin
            op = 6'h00;
            while (funct inside {6'h21, 6'h23, 6'h2a})
               funct = 6'($urandom);
         end
         K_ORI:  op = 6'h0d;
         K_LUI:  op = 6'h0f;
         K_LW:   op = 6'h23;
         K_SW:   op = 6'h2b;
         K_BEQ:  op = 6'h04;
         K_J:    op = 6'h02;
         K_JAL:  op = 6'h03;
         default: op = ill_op;
      endcase
      zero = z;
      ok   = (d <= WM);
      ret  = 1'b1;

      v = '0; v.ret = m_ret; v.pc_we = 1; v.ir_we = 1;
      tr.push_back(v); rdy.push_back(1'($urandom));

      v = '0; v.ret = m_ret;
      if (k == K_J || k == K_JAL) begin
         v.pc_we = 1; v.npc = 2'b10;
      end
      if (k == K_JAL) begin
         v.reg_we = 1; v.reg_dst = 2'b10; v.wb = 2'b10;
      end
      if (k == K_ILL || k == K_BADF) begin
         v.ill = 1; ret = 1'b0;
      end
      tr.push_back(v); rdy.push_back(1'($urandom));

      if (!(k inside {K_J, K_JAL, K_ILL, K_BADF})) begin
         v = '0; v.ret = m_ret;
         case (k)
            K_SUBU, K_BEQ: v.alu_op = 3'd1;
            K_SLT:         v.alu_op = 3'd3;
            K_ORI:         v.alu_op = 3'd2;
            K_LUI:         v.alu_op = 3'd4;
            default:       v.alu_op = 3'd0;
         endcase
         v.alu_src = k inside {K_ORI, K_LUI, K_LW, K_SW};
         if (k == K_BEQ && z) begin
            v.pc_we = 1; v.npc = 2'b01;
         end
         tr.push_back(v); rdy.push_back(1'($urandom));

         if (k == K_LW || k == K_SW) begin
            n = ok ? d + 1 : WM + 1;
            for (int i = 0; i < n; i++) begin
               v = '0; v.ret = m_ret;
               v.dm_re = (k == K_LW);
               v.dm_we = (k == K_SW);
               if (!ok && i == n - 1) v.merr = 1;
               tr.push_back(v);
               rdy.push_back(ok && i == d);
            end
            if (!ok) ret = 1'b0;
         end

         if (k inside {K_ADDU, K_SUBU, K_SLT, K_ORI, K_LUI} ||
             (k == K_LW && ok)) begin
            v = '0; v.ret = m_ret; v.reg_we = 1;
            v.reg_dst = (k <= K_SLT) ? 2'b01 : 2'b00;
            v.wb = (k == K_LW) ? 2'b01 : 2'b00;
            tr.push_back(v); rdy.push_back(1'($urandom));
         end
      end

      if (ret) m_ret++;
      foreach (tr[i]) exp_q.push_back(tr[i]);
      foreach (rdy[i]) begin
         dm_ready = rdy[i];
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_random(int cnt);
      int k, d, r;
      logic [5:0] io;
      for (int i = 0; i < cnt; i++) begin
         k = $urandom_range(0, 11);
         r = $urandom_range(0, 5);
         case (r)
            0: d = 0;
            1: d = WM;
            2: d = WM + 1;
            3: d = WM - 1;
            default: d = $urandom_range(0, 4);
         endcase
         io = 6'($urandom);
         while (legal_op(io)) io = 6'($urandom);
         run_instr(k, 1'($urandom), d, io);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; op = 6'h3f; funct = 6'h21;
      zero = 1'b1; dm_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_outputs", act, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;

      run_instr(K_ADDU, 1'b0, 0, 6'h3f);
      run_instr(K_LW,   1'b0, 2, 6'h3f);
      run_instr(K_BEQ,  1'b1, 0, 6'h3f);
      run_instr(K_BEQ,  1'b0, 0, 6'h3f);
      run_instr(K_JAL,  1'b0, 0, 6'h3f);
      run_instr(K_SW,   1'b0, WM + 1, 6'h3f);
      run_instr(K_ILL,  1'b0, 0, 6'h3f);
      run_instr(K_SW,   1'b0, WM, 6'h3f);
      run_instr(K_LW,   1'b0, WM + 1, 6'h3f);
      run_random(250);

      mon_en = 1'b0;
      op = 6'h2b; zero = 1'b0; dm_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("sw_req_before_rst", {63'd0, dm_we}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_drops_dm_we", {63'd0, dm_we}, 64'd0);
      chk("rst_outputs", act, 64'd0);
      chk("rst_retired", {32'd0, retired}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_ret = 0;
      mon_en = 1'b1;
      run_instr(K_ADDU, 1'b0, 0, 6'h3f);
      run_random(40);

      @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
